// File: rtl/miner_bus_pkg.sv
// Shared constants for the host-side loader of the miner CSR slave:
// register map, status bit positions, control words and loader states.
package miner_bus_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 5'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'd1;
    localparam logic [ADDR_W-1:0] ADDR_NONCE  = 5'd2;
    localparam logic [ADDR_W-1:0] ADDR_MSG    = 5'd3;
    localparam logic [ADDR_W-1:0] ADDR_TGT    = 5'd16;

    localparam int NUM_MSG_WORDS = 13;
    localparam int NUM_TGT_WORDS = 8;

    // Status bit 0 (complete) is informational and never steers the loader.
    localparam int STAT_FOUND     = 1;
    localparam int STAT_EXHAUSTED = 2;

    localparam logic [WORD_W-1:0] CTRL_SET = 32'h0000_0003;
    localparam logic [WORD_W-1:0] CTRL_CLR = 32'h0000_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_TGT,
        S_WR_MSG,
        S_CTRL_SET,
        S_CTRL_CLR,
        S_POLL_WAIT,
        S_POLL,
        S_RD_NONCE,
        S_FINISH
    } state_t;

endpackage

// File: rtl/avalon_word_xfer.sv
// Single-word Avalon-MM handshake: forwards the caller's request onto the bus
// (write wins over read), idles the bus at zero, and flags completion.
module avalon_word_xfer
    import miner_bus_pkg::*;
(
    input  logic              i_req_write,
    input  logic              i_req_read,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic              o_done,
    output logic [WORD_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_m_address,
    output logic              o_m_write,
    output logic              o_m_read,
    output logic [WORD_W-1:0] o_m_writedata,
    input  logic [WORD_W-1:0] i_m_readdata,
    input  logic              i_m_waitrequest
);

    logic w_read;
    logic w_active;

    // The caller holds its request steady until o_done, so the bus stays
    // stable through every stall cycle.
    assign w_read        = i_req_read & ~i_req_write;
    assign w_active      = i_req_write | w_read;
    assign o_m_write     = i_req_write;
    assign o_m_read      = w_read;
    assign o_m_address   = w_active ? i_addr : '0;
    assign o_m_writedata = i_req_write ? i_wdata : '0;
    assign o_done        = w_active & ~i_m_waitrequest;
    assign o_rdata       = i_m_readdata;

endmodule

// File: rtl/miner_host_loader.sv
// Host-side Avalon-MM master: loads one job into the miner CSR slave, pulses
// the new-target/new-message strobes, then polls status and reports the result.
module miner_host_loader
    import miner_bus_pkg::*;
#(
    parameter int POLL_GAP  = 16,
    parameter int MAX_POLLS = 65535
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [407:0]      job_msg,
    input  logic [255:0]      job_target,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic              exhausted,
    output logic              timeout,
    output logic [31:0]       nonce,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_write,
    output logic              m_read,
    output logic [WORD_W-1:0] m_writedata,
    input  logic [WORD_W-1:0] m_readdata,
    input  logic              m_waitrequest
);

    localparam logic [15:0] GAP_LAST   = 16'(POLL_GAP - 1);
    localparam logic [15:0] POLL_LIMIT = 16'(MAX_POLLS);
    localparam state_t      AFTER_READ = (POLL_GAP == 0) ? S_POLL : S_POLL_WAIT;

    state_t        r_state;
    logic [3:0]    r_idx;
    logic [15:0]   r_gap_cnt;
    logic [15:0]   r_poll_cnt;
    logic [407:0]  r_msg;
    logic [255:0]  r_tgt;
    logic          r_found;
    logic          r_exhausted;
    logic          r_timeout;
    logic [31:0]   r_nonce;

    logic              w_req_write;
    logic              w_req_read;
    logic [ADDR_W-1:0] w_addr;
    logic [WORD_W-1:0] w_wdata;
    logic [WORD_W-1:0] w_rdata;
    logic              w_xfer_done;
    logic [415:0]      w_msg_words;
    logic [8:0]        w_bit;
    logic [15:0]       w_poll_next;

    // Padding the header with the nonce-byte slot lines every register up on
    // a 32-bit boundary: word k of this vector is register 3+k.
    assign w_msg_words = {r_msg, 8'h00};
    assign w_bit       = {r_idx, 5'd0};
    assign w_poll_next = r_poll_cnt + 16'd1;

    // NOTE: defaults first so no path through the case leaves a latch.
    always_comb begin
        w_req_write = 1'b0;
        w_req_read  = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        case (r_state)
            S_WR_TGT: begin
                w_req_write = 1'b1;
                w_addr      = ADDR_TGT + {1'b0, r_idx};
                w_wdata     = r_tgt[w_bit +: 32];
            end
            S_WR_MSG: begin
                w_req_write = 1'b1;
                w_addr      = ADDR_MSG + {1'b0, r_idx};
                w_wdata     = w_msg_words[w_bit +: 32];
            end
            S_CTRL_SET: begin
                w_req_write = 1'b1;
                w_addr      = ADDR_CTRL;
                w_wdata     = CTRL_SET;
            end
            S_CTRL_CLR: begin
                w_req_write = 1'b1;
                w_addr      = ADDR_CTRL;
                w_wdata     = CTRL_CLR;
            end
            S_POLL: begin
                w_req_read = 1'b1;
                w_addr     = ADDR_STATUS;
            end
            S_RD_NONCE: begin
                w_req_read = 1'b1;
                w_addr     = ADDR_NONCE;
            end
            default: ;
        endcase
    end

    avalon_word_xfer u_xfer (
        .i_req_write     (w_req_write),
        .i_req_read      (w_req_read),
        .i_addr          (w_addr),
        .i_wdata         (w_wdata),
        .o_done          (w_xfer_done),
        .o_rdata         (w_rdata),
        .o_m_address     (m_address),
        .o_m_write       (m_write),
        .o_m_read        (m_read),
        .o_m_writedata   (m_writedata),
        .i_m_readdata    (m_readdata),
        .i_m_waitrequest (m_waitrequest)
    );

    // NOTE: job payload registers carry no reset; they only reach the bus
    // while the FSM is past IDLE, which requires a fresh capture.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) begin
            r_msg <= job_msg;
            r_tgt <= job_target;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_gap_cnt   <= '0;
            r_poll_cnt  <= '0;
            r_found     <= 1'b0;
            r_exhausted <= 1'b0;
            r_timeout   <= 1'b0;
            r_nonce     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_state     <= S_WR_TGT;
                    r_idx       <= '0;
                    r_poll_cnt  <= '0;
                    r_found     <= 1'b0;
                    r_exhausted <= 1'b0;
                    r_timeout   <= 1'b0;
                    r_nonce     <= '0;
                end
                S_WR_TGT: if (w_xfer_done) begin
                    if (r_idx == 4'(NUM_TGT_WORDS - 1)) begin
                        r_idx   <= '0;
                        r_state <= S_WR_MSG;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_WR_MSG: if (w_xfer_done) begin
                    if (r_idx == 4'(NUM_MSG_WORDS - 1)) begin
                        r_idx   <= '0;
                        r_state <= S_CTRL_SET;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_CTRL_SET: if (w_xfer_done) r_state <= S_CTRL_CLR;
                S_CTRL_CLR: if (w_xfer_done) begin
                    r_gap_cnt <= '0;
                    r_state   <= AFTER_READ;
                end
                S_POLL_WAIT: begin
                    if (r_gap_cnt == GAP_LAST) r_state <= S_POLL;
                    else r_gap_cnt <= r_gap_cnt + 16'd1;
                end
                S_POLL: if (w_xfer_done) begin
                    r_poll_cnt <= w_poll_next;
                    if (w_rdata[STAT_FOUND]) begin
                        r_state <= S_RD_NONCE;
                    end else if (w_rdata[STAT_EXHAUSTED]) begin
                        r_exhausted <= 1'b1;
                        r_state     <= S_FINISH;
                    end else if (w_poll_next == POLL_LIMIT) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_FINISH;
                    end else begin
                        r_gap_cnt <= '0;
                        r_state   <= AFTER_READ;
                    end
                end
                S_RD_NONCE: if (w_xfer_done) begin
                    r_nonce <= w_rdata;
                    r_found <= 1'b1;
                    r_state <= S_FINISH;
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign done      = (r_state == S_FINISH);
    assign found     = r_found;
    assign exhausted = r_exhausted;
    assign timeout   = r_timeout;
    assign nonce     = r_nonce;

endmodule

// File: tb/tb_miner_host_loader.sv
// Scoreboard bench for miner_host_loader: stimulus queues expected bus
// transfers and results; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_miner_host_loader;

    localparam int TB_GAP = 2;
    localparam int TB_MAX = 4;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [407:0] job_msg;
    logic [255:0] job_target;
    logic         busy, done, found, exhausted, timeout;
    logic [31:0]  nonce;
    logic [4:0]   m_address;
    logic         m_write, m_read;
    logic [31:0]  m_writedata;
    logic [31:0]  m_readdata;
    logic         m_waitrequest = 1'b0;

    miner_host_loader #(.POLL_GAP(TB_GAP), .MAX_POLLS(TB_MAX)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .job_msg       (job_msg),
        .job_target    (job_target),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .exhausted     (exhausted),
        .timeout       (timeout),
        .nonce         (nonce),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_read        (m_read),
        .m_writedata   (m_writedata),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct packed {
        logic        f;
        logic        e;
        logic        t;
        logic [31:0] n;
    } res_t;

    xfer_t exp_q[$];
    res_t  res_q[$];
    int    checks = 0;
    int    errors = 0;
    int    done_cnt = 0;

    // Slave model configuration and state.
    int          hit_poll = 0;
    logic [31:0] hit_status = 32'h0;
    logic [31:0] slave_nonce = 32'h0;
    bit          rand_wait = 1'b0;
    int          poll_seen = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    always_comb begin
        m_readdata = 32'h0;
        if (m_address == 5'd1)
            m_readdata = (hit_poll != 0 && poll_seen + 1 >= hit_poll) ? hit_status : 32'h0;
        else if (m_address == 5'd2)
            m_readdata = slave_nonce;
    end

    always @(posedge clk) begin
        if (m_read && !m_waitrequest && m_address == 5'd1)
            poll_seen <= poll_seen + 1;
        else if (m_write && !m_waitrequest && m_address == 5'd0 && m_writedata == 32'h3)
            poll_seen <= 0;
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_waitrequest = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b0;
    end

    // Monitor
    logic        prev_req = 1'b0;
    logic        prev_wait = 1'b0;
    logic        prev_done = 1'b0;
    logic [38:0] prev_bus = '0;
    logic [34:0] prev_res = '0;
    int          idle_run = 0;

    always @(negedge clk) begin
        xfer_t       e;
        res_t        r;
        logic [38:0] cur_bus;
        if (!n_rst) begin
            prev_req  = 1'b0;
            prev_done = 1'b0;
            idle_run  = 0;
        end else begin
            cur_bus = {m_write, m_read, m_address, m_writedata};
            if (m_write && m_read) fail_now("read_write_together");
            if (m_write || m_read) begin
                if (m_address > 5'd23) check("addr_range", 96'(m_address), 96'd23);
                if (prev_req && prev_wait)
                    check("hold_during_stall", 96'(cur_bus), 96'(prev_bus));
                else if (!prev_req && m_read && m_address == 5'd1)
                    check("poll_gap", 96'(idle_run), 96'(TB_GAP));
                if (!m_waitrequest) begin
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_xfer: actual=%0h required=none", cur_bus);
                        checks++;
                        errors++;
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_kind_addr", 96'({m_write, m_address}), 96'({e.is_wr, e.addr}));
                        if (e.is_wr) check("xfer_wdata", 96'(m_writedata), 96'(e.data));
                    end
                end
                idle_run = 0;
            end else begin
                idle_run++;
            end
            prev_req  = m_write || m_read;
            prev_wait = m_waitrequest;
            prev_bus  = cur_bus;

            if (prev_done)
                check("result_hold", 96'({found, exhausted, timeout, nonce}), 96'(prev_res));
            if (done) begin
                done_cnt++;
                check("done_one_cycle", 96'(prev_done), 96'd0);
                check("busy_at_done", 96'(busy), 96'd0);
                check("xfers_pending", 96'(exp_q.size()), 96'd0);
                if (res_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    r = res_q.pop_front();
                    check("result_flags", 96'({found, exhausted, timeout}), 96'({r.f, r.e, r.t}));
                    check("result_nonce", 96'(nonce), 96'(r.n));
                end
                prev_res = {found, exhausted, timeout, nonce};
            end
            prev_done = done;
        end
    end

    // Hand-derived register images for the 01..33 header and 0000_FF..FF target.
    task automatic push_job();
        logic [7:0] b0;
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{1'b1, 5'(16 + i), (i == 7) ? 32'h0000_FFFF : 32'hFFFF_FFFF});
        exp_q.push_back('{1'b1, 5'd3, 32'h3132_3300});
        for (int j = 0; j < 12; j++) begin
            b0 = 8'(45 - 4 * j);
            exp_q.push_back('{1'b1, 5'(4 + j), {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3}});
        end
        exp_q.push_back('{1'b1, 5'd0, 32'h3});
        exp_q.push_back('{1'b1, 5'd0, 32'h0});
    endtask

    task automatic push_reads(input int n_status, input bit with_nonce);
        for (int i = 0; i < n_status; i++) exp_q.push_back('{1'b0, 5'd1, 32'h0});
        if (with_nonce) exp_q.push_back('{1'b0, 5'd2, 32'h0});
    endtask

    task automatic start_job();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 96'(busy), 96'd1);
        check("results_cleared", 96'({found, exhausted, timeout, nonce}), 96'd0);
        check("first_write", 96'({m_write, m_read, m_address}), 96'({1'b1, 1'b0, 5'd16}));
    endtask

    task automatic wait_done(input int budget);
        int target;
        int n;
        target = done_cnt + 1;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 96'(done_cnt), 96'(target));
        repeat (4) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 96'({busy, done, found, exhausted, timeout, nonce,
                         m_address, m_write, m_read, m_writedata}), 96'd0);
    endtask

    initial begin
        for (int b = 0; b < 51; b++) job_msg[8*b +: 8] = 8'(51 - b);
        job_target = {16'h0000, {240{1'b1}}};

        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        n_rst = 1'b1;
        @(negedge clk);

        // Found on the third poll, no wait states.
        hit_poll = 3; hit_status = 32'h3; slave_nonce = 32'h1234_5678;
        push_job(); push_reads(3, 1'b1);
        res_q.push_back('{1'b1, 1'b0, 1'b0, 32'h1234_5678});
        start_job();
        wait_done(400);

        // Same job with random stalls.
        rand_wait = 1'b1;
        push_job(); push_reads(3, 1'b1);
        res_q.push_back('{1'b1, 1'b0, 1'b0, 32'h1234_5678});
        start_job();
        wait_done(2000);
        rand_wait = 1'b0;
        repeat (2) @(negedge clk);

        // Exhausted on the first poll: no nonce read.
        hit_poll = 1; hit_status = 32'h4;
        push_job(); push_reads(1, 1'b0);
        res_q.push_back('{1'b0, 1'b1, 1'b0, 32'h0});
        start_job();
        wait_done(400);

        // Status never set: timeout after TB_MAX reads.
        hit_poll = 0; hit_status = 32'h0;
        push_job(); push_reads(TB_MAX, 1'b0);
        res_q.push_back('{1'b0, 1'b0, 1'b1, 32'h0});
        start_job();
        wait_done(400);

        // Found and exhausted together: found wins; start during polling ignored.
        hit_poll = 2; hit_status = 32'h6; slave_nonce = 32'hCAFE_0006;
        push_job(); push_reads(2, 1'b1);
        res_q.push_back('{1'b1, 1'b0, 1'b0, 32'hCAFE_0006});
        start_job();
        repeat (26) @(negedge clk);
        check("busy_while_polling", 96'(busy), 96'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);

        // Reset in the middle of the message writes, then a clean restart.
        hit_poll = 1; hit_status = 32'h2; slave_nonce = 32'hA5A5_0001;
        push_job();
        start_job();
        repeat (12) @(negedge clk);
        check("in_msg_writes", 96'({m_write, m_address >= 5'd3 && m_address <= 5'd15}), 96'({1'b1, 1'b1}));
        #2 n_rst = 1'b0;
        #1 check_all_zero("async_reset_outputs");
        exp_q.delete();
        res_q.delete();
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        push_job(); push_reads(1, 1'b1);
        res_q.push_back('{1'b1, 1'b0, 1'b0, 32'hA5A5_0001});
        start_job();
        wait_done(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/miner_host_loader.md
# miner_host_loader

Avalon-MM master that drives the miner's 24-word CSR slave from the host side. It accepts one mining job (408-bit message header, 256-bit target), writes it into the slave register file, and raises the new-target/new-message strobes. It then polls the status word until the miner reports a found nonce, nonce-space exhaustion, or a poll timeout, and returns the result. It sits between the job-dispatch logic and the miner's slave port, and is the write/poll counterpart of that slave.

## Interface
- POLL_GAP, 16: idle cycles between consecutive status reads (0 = back-to-back).
- MAX_POLLS, 65535: status reads before timeout; 16-bit poll counter.
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- job_msg  in  408  header without nonce; captured on accepted start.
- job_target  in  256  target; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- found  out  1  miner reported a valid nonce; held until next accepted start.
- exhausted  out  1  nonce space exhausted without a hit; held.
- timeout  out  1  MAX_POLLS reached without found or exhausted; held.
- nonce  out  32  winning nonce when found=1, else 0; held.
- m_address  out  5  word address.
- m_write  out  1  write request.
- m_read  out  1  read request.
- m_writedata  out  32  write data.
- m_readdata  in  32  read data; valid in the cycle m_read=1 and m_waitrequest=0.
- m_waitrequest  in  1  slave stall.

## Operation
- Register map: 0 control (bit0 newTarget, bit1 newMsg); 1 status (bit0 complete, bit1 found, bit2 exhausted); 2 found nonce; 3..15 message; 16..23 target.
- Word packing:
  - reg16+i = target[32i+31:32i] for i=0..7.
  - reg3 = {msg[23:0], 8'h00}.
  - reg4+j = msg[32j+55:32j+24] for j=0..11, so reg15 = msg[407:376].
- States:
  - IDLE: on start, capture inputs; clear found, exhausted, timeout and nonce; go to WR_TGT.
  - WR_TGT: write addresses 16..23 in ascending order.
  - WR_MSG: write addresses 3..15 in ascending order.
  - CTRL_SET: write reg0 = 32'h3.
  - CTRL_CLR: write reg0 = 32'h0. This rearms the slave's rising-edge detectors.
  - POLL_WAIT: wait POLL_GAP cycles.
  - POLL: read reg1, then branch:
    - found bit set: go to RD_NONCE.
    - exhausted bit set (found clear): set exhausted, go to FINISH.
    - neither bit set, poll counter at MAX_POLLS: set timeout, go to FINISH.
    - otherwise: go to POLL_WAIT.
  - RD_NONCE: read reg2, latch nonce, set found, go to FINISH.
  - FINISH: pulse done for one cycle, then IDLE.
- Transfer rule: request signals and address/data stay stable while m_waitrequest=1. A transfer completes in the cycle where the request is high and m_waitrequest=0. The word index advances only on completion.
- Never assert m_read and m_write together. Never address outside 0..23.
- start while busy is ignored. The status complete bit is informational only and is not a termination condition.
- If found and exhausted are read set together, found wins.

## Timing
- Reset: every output is 0 and state is IDLE. Reset mid-transfer drops m_write/m_read in the same cycle, asynchronously.
- With no wait states, the first write (address 16) is issued the cycle after start. There are 23 writes on consecutive cycles, so CTRL_CLR completes 23 cycles after start.
- The first status read is issued POLL_GAP cycles after CTRL_CLR completes.
- done asserts the cycle after the terminating read completes. Result outputs are valid in that same cycle and remain stable.
- busy drops in the cycle done is high.
- The poll counter counts completed status reads only; waitrequest stalls do not count.

## Structure
- Package miner_bus_pkg: register address constants, status bit indices, control values, state enum.
- Sub-module avalon_word_xfer: single-word read/write handshake. It takes a request with address and data, holds it through waitrequest, and returns done plus read data. The top-level FSM sequences words through it.

## Test plan
- No wait states; msg = 408'h01..33, target = 256'h0000_FFFF..FF; slave sets found with nonce 32'h1234_5678 on the 3rd poll. Expected:
  - write addresses 16..23 then 3..15, reg0 = 3 then 0.
  - reg3 data = {msg[23:0], 8'h00}.
  - done pulse with found=1, nonce=32'h1234_5678.
- Random m_waitrequest (50%) on the same job: identical write/read sequence and data; address, data and request held during stalls.
- Slave returns status = 32'h4 on the first poll: done with exhausted=1, found=0, nonce=0, and no read of reg2.
- MAX_POLLS=4, POLL_GAP=2, status always 0: exactly 4 status reads spaced ≥2 idle cycles apart, then done with timeout=1.
- Slave returns status = 32'h6: found takes priority and reg2 is read. A start pulse during polling is ignored.
- Assert n_rst mid-WR_MSG: outputs go to 0 immediately. The next start restarts the job at address 16.
